// File: rtl/issue_scoreboard.sv
// Single-entry issue stage with a per-register busy scoreboard (RAW/WAW interlock).
// Optional: define ISSUE_STALL_CNT_EN to add the saturating stall_cnt output.
module issue_scoreboard #(
    parameter int NREG   = 32,
    parameter int INST_W = 45
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dec_valid,
    input  logic [INST_W-1:0] dec_inst,
    output logic              dec_ready,
    output logic              iss_valid,
    output logic [INST_W-1:0] iss_inst,
    input  logic              iss_ready,
    input  logic              wb_valid,
    input  logic [4:0]        wb_rd,
    input  logic              flush,
`ifdef ISSUE_STALL_CNT_EN
    output logic [NREG-1:0]   sb_busy,
    output logic [31:0]       stall_cnt
`else
    output logic [NREG-1:0]   sb_busy
`endif
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_HAZ   = 2'd1,
        S_RDY   = 2'd2
    } state_t;

    state_t            r_state;
    logic [INST_W-1:0] r_inst;
    logic [NREG-1:0]   r_busy;

    logic [4:0]      w_rs1, w_rs2, w_rd;
    logic [NREG-1:0] w_wb_clr;
    logic [NREG-1:0] w_beff;
    logic [NREG-1:0] w_fire_set;
    logic [NREG-1:0] w_busy_nxt;
    logic            w_full;
    logic            w_hazard;
    logic            w_fire;
    logic            w_take;
    logic            w_new_haz;

    assign w_rs1 = r_inst[44:40];
    assign w_rs2 = r_inst[39:35];
    assign w_rd  = r_inst[34:30];

    // Writeback is bypassed: a register retiring this cycle no longer blocks.
    assign w_wb_clr = wb_valid ? ({{(NREG-1){1'b0}}, 1'b1} << wb_rd) : '0;
    assign w_beff   = r_busy & ~w_wb_clr;

    assign w_full    = (r_state != S_EMPTY);
    assign w_hazard  = w_beff[w_rs1] | w_beff[w_rs2] | w_beff[w_rd];
    assign iss_valid = w_full & ~w_hazard;
    assign iss_inst  = r_inst;
    assign w_fire    = iss_valid & iss_ready;
    assign dec_ready = ~w_full | w_fire | flush;
    assign sb_busy   = r_busy;

    // Bubbles (opc == 0) are accepted but never occupy the entry.
    assign w_take = dec_valid & dec_ready & (dec_inst[9:0] != 10'd0);

    // Set-on-fire is ORed after the writeback clear, so it wins on a collision.
    assign w_fire_set = (w_fire && (w_rd != 5'd0)) ? ({{(NREG-1){1'b0}}, 1'b1} << w_rd) : '0;
    assign w_busy_nxt = (w_beff | w_fire_set) & ~{{(NREG-1){1'b0}}, 1'b1};

    assign w_new_haz = w_busy_nxt[dec_inst[44:40]] | w_busy_nxt[dec_inst[39:35]]
                     | w_busy_nxt[dec_inst[34:30]];

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values computed above.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_EMPTY;
            r_inst  <= '0;
            r_busy  <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            if (w_take) begin
                r_inst  <= dec_inst;
                r_state <= w_new_haz ? S_HAZ : S_RDY;
            end else if (w_fire || flush) begin
                r_state <= S_EMPTY;
            end else if (r_state == S_HAZ && !w_hazard) begin
                r_state <= S_RDY;
            end
        end
    end

`ifdef ISSUE_STALL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (w_full && !w_fire && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule
